// File: rtl/sequenciador_mux4.sv
// Round-robin sequencer driving the select/enable inputs of a 4:1 mux.
// Each requesting channel is granted a fixed slot of SLOT cycles; a slot
// may end early when its requester drops. Priority rotates so that the
// channel whose slot just ended is considered last.
module sequenciador_mux4 #(
    parameter int SLOT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       hold,
    output logic [1:0] sel,
    output logic       enable,
    output logic [3:0] grant,
    output logic       fim_slot
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] LAST = 8'(SLOT - 1);

    state_t     state, state_next;
    logic [1:0] ptr, ptr_next;
    logic [1:0] sel_next;
    logic [7:0] cnt, cnt_next;
    logic       enable_next;
    logic [3:0] grant_next;
    logic [2:0] arb;

    // Returns {found, winner}: first requester in the order p, p+1, p+2, p+3.
    function automatic logic [2:0] arbitrate(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] c;
        res = 3'b000;
        // Walk backwards so the lowest offset from p overwrites the rest.
        for (int k = 3; k >= 0; k--) begin
            c = p + 2'(k);
            if (r[c]) begin
                res = {1'b1, c};
            end
        end
        return res;
    endfunction

    assign arb = arbitrate(req, ptr);

    // Slot ends on the last counted cycle (not while frozen) or when the
    // granted channel withdraws its request, even under hold.
    assign fim_slot = enable & (((cnt == LAST) & ~hold) | ~req[sel]);

    // State and output registers; reset wins over every other input.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= 2'd0;
            cnt    <= 8'd0;
            sel    <= 2'd0;
            enable <= 1'b0;
            grant  <= 4'b0000;
        end else begin
            state  <= state_next;
            ptr    <= ptr_next;
            cnt    <= cnt_next;
            sel    <= sel_next;
            enable <= enable_next;
            grant  <= grant_next;
        end
    end

    // Next-state logic: arbitration, slot counting and slot-end handover.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        cnt_next   = cnt;
        sel_next   = sel;
        case (state)
            IDLE: begin
                if (!hold && arb[2]) begin
                    state_next = GRANT;
                    sel_next   = arb[1:0];
                    ptr_next   = arb[1:0] + 2'd1;
                    cnt_next   = 8'd0;
                end
            end
            GRANT: begin
                if (fim_slot) begin
                    if (arb[2]) begin
                        sel_next = arb[1:0];
                        ptr_next = arb[1:0] + 2'd1;
                        cnt_next = 8'd0;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (!hold) begin
                    cnt_next = cnt + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered mux controls follow the next state; grant mirrors sel.
    always_comb begin
        enable_next = (state_next == GRANT);
        grant_next  = enable_next ? (4'b0001 << sel_next) : 4'b0000;
    end

endmodule

// File: tb/tb_sequenciador_mux4.sv
// Bench for sequenciador_mux4: a SLOT=4 and a SLOT=1 instance are checked
// every cycle against a slot-level reference model, plus directed checks.
module tb_sequenciador_mux4;

    logic       clock = 1'b0;
    logic       reset4, hold4, reset1, hold1;
    logic [3:0] req4, req1;
    logic [1:0] sel4, sel1;
    logic       en4, en1, fim4, fim1;
    logic [3:0] gr4, gr1;

    int errors = 0;
    int checks = 0;

    // Reference model state per instance (0: SLOT=4, 1: SLOT=1).
    int m_act[2];
    int m_sel[2];
    int m_ptr[2];
    int m_used[2];
    int slot_len[2] = '{4, 1};

    // Outputs observed in the most recent step, for directed checks.
    logic [1:0] o_sel, o1_sel;
    logic       o_en, o_fim, o1_en, o1_fim;
    logic [3:0] o_gr;
    int         en_cnt;

    always #5 clock = ~clock;

    sequenciador_mux4 #(.SLOT(4)) dut4 (
        .clock(clock), .reset(reset4), .req(req4), .hold(hold4),
        .sel(sel4), .enable(en4), .grant(gr4), .fim_slot(fim4)
    );

    sequenciador_mux4 #(.SLOT(1)) dut1 (
        .clock(clock), .reset(reset1), .req(req1), .hold(hold1),
        .sel(sel1), .enable(en1), .grant(gr1), .fim_slot(fim1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin winner starting at p, or -1 if nobody requests.
    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic exp_fim(input int d, input logic [3:0] r, input logic h);
        if (m_act[d] == 0) return 1'b0;
        if (r[m_sel[d]] == 1'b0) return 1'b1;
        return (m_used[d] == slot_len[d] - 1) && !h;
    endfunction

    function automatic logic [3:0] exp_grant(input int d);
        return (m_act[d] != 0) ? 4'(1 << m_sel[d]) : 4'b0000;
    endfunction

    task automatic give(input int d, input int w);
        m_sel[d]  = w;
        m_ptr[d]  = (w + 1) % 4;
        m_used[d] = 0;
        m_act[d]  = 1;
    endtask

    task automatic model_edge(input int d, input logic [3:0] r, input logic h, input logic rs);
        int  w;
        logic ends;
        ends = exp_fim(d, r, h);
        w    = pick(r, m_ptr[d]);
        if (rs) begin
            m_act[d] = 0; m_sel[d] = 0; m_ptr[d] = 0; m_used[d] = 0;
        end else if (m_act[d] == 0) begin
            if (!h && w >= 0) give(d, w);
        end else if (ends) begin
            if (w >= 0) give(d, w);
            else m_act[d] = 0;
        end else if (!h) begin
            m_used[d]++;
        end
    endtask

    task automatic step(input logic [3:0] r4, input logic h4, input logic rs4,
                        input logic [3:0] r1, input logic h1, input logic rs1);
        req4 = r4; hold4 = h4; reset4 = rs4;
        req1 = r1; hold1 = h1; reset1 = rs1;
        #1;
        chk("sel4",   32'(sel4), 32'(m_sel[0]));
        chk("en4",    32'(en4),  32'(m_act[0]));
        chk("grant4", 32'(gr4),  32'(exp_grant(0)));
        chk("fim4",   32'(fim4), 32'(exp_fim(0, r4, h4)));
        chk("sel1",   32'(sel1), 32'(m_sel[1]));
        chk("en1",    32'(en1),  32'(m_act[1]));
        chk("grant1", 32'(gr1),  32'(exp_grant(1)));
        chk("fim1",   32'(fim1), 32'(exp_fim(1, r1, h1)));
        o_sel = sel4; o_en = en4; o_gr = gr4; o_fim = fim4;
        o1_sel = sel1; o1_en = en1; o1_fim = fim1;
        @(posedge clock);
        model_edge(0, r4, h4, rs4);
        model_edge(1, r1, h1, rs1);
        #1;
    endtask

    initial begin
        int exp3[5] = '{0, 1, 3, 0, 1};
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 0; m_sel[d] = 0; m_ptr[d] = 0; m_used[d] = 0;
        end
        req4 = 4'hF; hold4 = 1'b0; reset4 = 1'b1;
        req1 = 4'h0; hold1 = 1'b0; reset1 = 1'b1;
        @(posedge clock);
        #1;

        // Reset held for a second cycle with all requests active, then released.
        step(4'hF, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1);
        chk("rst_en",  32'(o_en),  32'd0);
        chk("rst_sel", 32'(o_sel), 32'd0);
        chk("rst_gr",  32'(o_gr),  32'd0);
        chk("rst_fim", 32'(o_fim), 32'd0);
        step(4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        chk("idle_en",  32'(o_en),  32'd0);
        chk("idle_sel", 32'(o_sel), 32'd0);
        chk("idle_gr",  32'(o_gr),  32'd0);

        // Single requester on channel 2: back-to-back regrants.
        for (int c = 0; c < 10; c++) begin
            step(4'b0100, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
            if (c == 1) begin
                chk("single_sel", 32'(o_sel), 32'd2);
                chk("single_gr",  32'(o_gr),  32'h4);
            end
            if (c >= 1) chk("single_en", 32'(o_en), 32'd1);
            if (c >= 1) chk("single_fim", 32'(o_fim), (c % 4 == 0) ? 32'd1 : 32'd0);
        end
        step(4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1);

        // Rotation with req=1011: 0, 1, 3, 0, 1.
        for (int c = 0; c < 18; c++) begin
            step(4'b1011, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
            if (c >= 1 && (c - 1) % 4 == 0) chk("rot_sel", 32'(o_sel), 32'(exp3[(c - 1) / 4]));
        end
        step(4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1);

        // Early release of channel 1 while channel 3 waits.
        step(4'b1010, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        step(4'b1010, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        chk("early_sel1", 32'(o_sel), 32'd1);
        step(4'b1000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        chk("early_fim", 32'(o_fim), 32'd1);
        step(4'b1000, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        chk("early_sel3", 32'(o_sel), 32'd3);
        chk("early_en",   32'(o_en),  32'd1);
        step(4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1);

        // Hold for 3 cycles at cnt=1 stretches the slot to 7 enable cycles.
        en_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            step(4'b0001, (c >= 2 && c <= 4), 1'b0, 4'h0, 1'b0, 1'b1);
            if (o_en) en_cnt++;
            if (c >= 2 && c <= 4) chk("hold_fim", 32'(o_fim), 32'd0);
            if (c >= 1) chk("hold_sel", 32'(o_sel), 32'd0);
            if (c == 6) chk("hold_fim_early", 32'(o_fim), 32'd0);
            if (c == 7) chk("hold_fim_end", 32'(o_fim), 32'd1);
        end
        chk("hold_len", 32'(en_cnt), 32'd7);
        step(4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1);

        // Reset at cnt=2 of a channel-2 slot; ptr must restart at 0.
        step(4'b0100, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        step(4'b0100, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        step(4'b0100, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        step(4'b0100, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1);
        step(4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        chk("mid_en",  32'(o_en),  32'd0);
        chk("mid_sel", 32'(o_sel), 32'd0);
        chk("mid_gr",  32'(o_gr),  32'd0);
        step(4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        chk("mid_ptr_sel", 32'(o_sel), 32'd0);
        chk("mid_ptr_en",  32'(o_en),  32'd1);

        // SLOT=1 instance with all requests: one cycle per channel.
        for (int c = 0; c < 6; c++) begin
            step(4'h0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
            if (c >= 1) begin
                chk("s1_sel", 32'(o1_sel), 32'((c - 1) % 4));
                chk("s1_fim", 32'(o1_fim), 32'd1);
            end
        end

        // Randomized traffic on both instances against the model.
        for (int c = 0; c < 400; c++) begin
            step(4'($urandom), ($urandom % 4 == 0), ($urandom % 60 == 0),
                 4'($urandom), ($urandom % 4 == 0), ($urandom % 60 == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
